// File: rtl/game_timer_pkg.sv
// Shared types and constants for the BCD game clock.
package game_timer_pkg;

  // Game-level state of the clock.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } timer_state_t;

  // One packed BCD digit.
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_UNITS_MAX   = 4'd9;
  localparam bcd_t BCD_TENS_MAX    = 4'd5;
  localparam bcd_t BCD_MINUTES_MAX = 4'd9;

  // Next value of a digit that wraps to zero after max. The >= keeps a digit
  // that somehow sits above max from ever climbing further.
  function automatic bcd_t bcd_next(input bcd_t d, input bcd_t max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with synchronous clear, increment enable and a carry out
// that fires on the increment which wraps the digit back to zero.
module bcd_digit_counter
  import game_timer_pkg::*;
#(
  parameter bcd_t MAX = BCD_UNITS_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output bcd_t digit,
  output logic carry
);

  assign carry = inc && (digit >= MAX);

  // Digit register: clear wins over increment so a clear on a tick edge zeroes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (inc) begin
      digit <= bcd_next(digit, MAX);
    end
  end

endmodule

// File: rtl/game_timer.sv
// BCD game clock: one-second prescaler, start/pause/expire FSM and cascaded
// seconds/minutes digit counters. Every output is a register or a direct
// decode of the state register, so Time never glitches.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 31_500_000,
  parameter int MINUTES_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause_toggle,
  input  logic       clear,
  output logic [7:0] Time,
  output logic [3:0] Minutes,
  output logic       sec_tick,
  output logic       running,
  output logic       time_up
);

  localparam int                  PRESC_W    = $clog2(TICKS_PER_SEC);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESC_W-1:0]  PRESC_ONE  = PRESC_W'(1);
  localparam bit                  LIMIT_EN   = (MINUTES_LIMIT != 0);
  localparam bcd_t                LIMIT_BCD  = 4'(MINUTES_LIMIT);

  timer_state_t         state;
  timer_state_t         state_next;
  logic [PRESC_W-1:0]   prescaler;

  logic start_accept;
  logic sec_edge;
  logic tick_inc;
  logic digit_clr;
  logic expire_event;

  bcd_t units_digit;
  bcd_t tens_digit;
  bcd_t minutes_digit;
  bcd_t minutes_after;
  logic units_carry;
  logic tens_carry;
  logic minutes_carry;

  // start only takes effect when the game is not already in progress.
  assign start_accept = start && ((state == ST_IDLE) || (state == ST_EXPIRED));

  // A second elapses on the last prescaler count while running; clear on the
  // same edge suppresses the increment.
  assign sec_edge  = (state == ST_RUNNING) && (prescaler == PRESC_LAST);
  assign tick_inc  = sec_edge && !clear;
  assign digit_clr = clear || start_accept;

  // Value the minutes digit takes on this tick's minute carry; expiry fires
  // when that value reaches the limit.
  assign minutes_after = minutes_carry ? 4'd0 : (minutes_digit + 4'd1);
  assign expire_event  = LIMIT_EN && tens_carry && (minutes_after == LIMIT_BCD);

  bcd_digit_counter #(.MAX(BCD_UNITS_MAX)) u_units (
    .clk   (clk),
    .reset (reset),
    .inc   (tick_inc),
    .clr   (digit_clr),
    .digit (units_digit),
    .carry (units_carry)
  );

  bcd_digit_counter #(.MAX(BCD_TENS_MAX)) u_tens (
    .clk   (clk),
    .reset (reset),
    .inc   (units_carry),
    .clr   (digit_clr),
    .digit (tens_digit),
    .carry (tens_carry)
  );

  bcd_digit_counter #(.MAX(BCD_MINUTES_MAX)) u_minutes (
    .clk   (clk),
    .reset (reset),
    .inc   (tens_carry),
    .clr   (digit_clr),
    .digit (minutes_digit),
    .carry (minutes_carry)
  );

  // Prescaler counts only while running and holds while paused so a partial
  // second survives a pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (digit_clr) begin
      prescaler <= '0;
    end else if (state == ST_RUNNING) begin
      prescaler <= sec_edge ? '0 : prescaler + PRESC_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: clear beats start beats expiry beats pause_toggle.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else if (start_accept) begin
      state_next = ST_RUNNING;
    end else begin
      case (state)
        ST_RUNNING: begin
          if (expire_event) begin
            state_next = ST_EXPIRED;
          end else if (pause_toggle) begin
            state_next = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (pause_toggle) begin
            state_next = ST_RUNNING;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  // sec_tick is registered so it lines up with the new Time value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= tick_inc;
    end
  end

  assign Time    = {tens_digit, units_digit};
  assign Minutes = minutes_digit;
  assign running = (state == ST_RUNNING);
  assign time_up = (state == ST_EXPIRED);

endmodule

// File: doc/game_timer.md
# game_timer

BCD game clock that produces the `Time` seconds value and a minute count consumed by the downstream time/monster controller. It has three parts:
- a one-second prescaler driven from the system clock;
- a start/pause/expire state machine;
- cascaded BCD digit counters.

It runs in the VGA clock domain and drives the on-screen timer and the game-over condition.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 31_500_000: clock cycles per game second. Must be ≥ 2.
- `MINUTES_LIMIT`, default 3: minute count at which the game expires. 0 means no limit.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins or restarts the game.
- `pause_toggle` in 1: one-cycle pulse; toggles between RUNNING and PAUSED.
- `clear` in 1: one-cycle pulse; returns to IDLE and zeroes all counts.
- `Time` out 8: BCD seconds. `[7:4]` is tens (0–5), `[3:0]` is units (0–9).
- `Minutes` out 4: BCD minutes (0–9).
- `sec_tick` out 1: one-cycle pulse in the cycle the new `Time` value first appears.
- `running` out 1: high in the RUNNING state.
- `time_up` out 1: high in the EXPIRED state.

## Operation
- States: IDLE, RUNNING, PAUSED, EXPIRED.
- Reset values:
  - state = IDLE;
  - prescaler = 0;
  - `Time` = 8'h00, `Minutes` = 4'h0;
  - `sec_tick` = 0, `running` = 0, `time_up` = 0.
- Input priority, highest first: `reset` > `clear` > `start` > `pause_toggle`.
- `clear`, in any state: go to IDLE, prescaler = 0, `Time` = 00, `Minutes` = 0.
- `start`:
  - in IDLE or EXPIRED: go to RUNNING, zero the prescaler and all digits;
  - in RUNNING or PAUSED: ignored.
- `pause_toggle`:
  - RUNNING → PAUSED, PAUSED → RUNNING;
  - ignored in IDLE and EXPIRED.
- Prescaler:
  - counts 0..`TICKS_PER_SEC`-1, only in RUNNING;
  - holds its value in PAUSED, so a partial second is preserved;
  - width is `$clog2(TICKS_PER_SEC)`.
- Second tick (RUNNING with prescaler == `TICKS_PER_SEC`-1):
  - prescaler → 0;
  - seconds increment;
  - `sec_tick` = 1 for that one cycle.
- BCD rules:
  - units 9 → 0 with carry to tens;
  - tens 5 with units 9 → `Time` 00 with carry to minutes;
  - minutes 9 → 0 (only reachable when `MINUTES_LIMIT` = 0);
  - no digit ever holds a value above 9, and tens never holds a value above 5.
- Expiry: if a minute carry makes `Minutes` == `MINUTES_LIMIT` (nonzero limit), go to EXPIRED on the same edge.
  - `Time` = 00; `Minutes` holds the limit.
  - No further ticks occur.
- Simultaneous events:
  - `pause_toggle` on a tick edge in RUNNING: the increment is applied, then the state becomes PAUSED.
  - `start` and `pause_toggle` together in IDLE: `start` wins.
  - `clear` on a tick edge: no increment; the counts are zeroed.

## Timing
- All outputs are registered. `running` and `time_up` are decoded from the state register.
- `start` sampled at edge k:
  - state = RUNNING and prescaler = 0 after edge k;
  - first tick at edge k+`TICKS_PER_SEC`, where `Time` becomes 01 and `sec_tick` = 1.
- Subsequent ticks are spaced exactly `TICKS_PER_SEC` cycles apart while RUNNING.
- PAUSED cycles add to that spacing one-for-one.
- `sec_tick` and the updated `Time` and `Minutes` change on the same edge.
- The downstream controller samples `Time` directly, so `Time` must be glitch-free: it is register outputs only.
- Asynchronous `reset` asserted mid-RUNNING: all outputs take their reset values immediately, without waiting for a clock edge.

## Structure
- Package `game_timer_pkg`:
  - state enum `timer_state_t`;
  - typedef `bcd_t` (logic [3:0]);
  - constants `BCD_UNITS_MAX` = 9 and `BCD_TENS_MAX` = 5.
- Sub-module `bcd_digit_counter`:
  - parameter `MAX`;
  - inputs `inc` and `clr`; outputs `digit` and `carry`;
  - instantiated three times: units, tens, minutes.
- The top level holds the prescaler, the FSM, and the expiry compare.

## Test plan
All scenarios use `TICKS_PER_SEC` = 4.
- Reset asserted with no clock edge → `Time` = 00, `Minutes` = 0, all pulse/status outputs 0. `pause_toggle` in IDLE → no change.
- `start`, then 60 ticks → `Time` = 01..09, 10..59, 00.
  - `Minutes` = 1 on the 60th tick;
  - exactly 60 `sec_tick` pulses, 4 cycles apart;
  - units never above 9, tens never above 5.
- `start`, 2 RUNNING cycles, `pause_toggle`, 20 cycles, `pause_toggle` → the next tick arrives exactly 2 cycles after resume, and `Time` = 01.
- `MINUTES_LIMIT` = 1 → after 60 ticks, `time_up` = 1, `running` = 0, `Time` = 00, `Minutes` = 1, and no further `sec_tick` over 40 cycles.
  - Then `start` → RUNNING from 00, `Minutes` = 0.
- `pause_toggle` coincident with a tick edge → `Time` increments and the state is PAUSED. `clear` coincident with a tick → `Time` = 00 and IDLE.
- Asynchronous `reset` mid-second, with `Time` = 37 → outputs zero before the next edge. After release, `start` → the first tick comes 4 cycles later.
